// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  // Extract a bit field of the given width starting at lsb.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

  // Clear the word-offset bits to form the line-aligned address.
  function automatic logic [63:0] line_addr(input logic [63:0] addr,
                                            input int unsigned off_w);
    return (addr >> off_w) << off_w;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one write port,
// combinational read by index, flash clear of all valid bits.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int unsigned SETS   = 64,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned TAG_W  = 22,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              clear_all,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // Valid bits: clear-all takes priority over setting the refilled line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage, unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache_direct_mapped_param.sv
// Direct-mapped instruction cache with request/valid refill handshake.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_COUNTERS_EN.
module icache_direct_mapped_param
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned SETS           = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req,
  input  logic [ADDR_W-1:0]                 address,
  input  logic                              flush,
  output logic [31:0]                       instruction,
  output logic                              hit,
  output logic                              busy,
  output logic                              mem_req,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic                              mem_valid,
  input  logic [32*WORDS_PER_LINE-1:0]      mem_data
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
`endif
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W = INSTR_W * WORDS_PER_LINE;

  state_t              state, state_n;
  logic [INSTR_W-1:0]  instr_q, instr_n;
  logic                hit_q, hit_n;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_n;
  logic [TAG_W-1:0]    lat_tag, lat_tag_n;
  logic [IDX_W-1:0]    lat_idx, lat_idx_n;
  logic [OFF_W-1:0]    lat_off, lat_off_n;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_off;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                wr_en;
  logic                lookup_hit;
  logic                miss_start;

  assign req_off = OFF_W'(addr_field(64'(address), 0, OFF_W));
  assign req_idx = IDX_W'(addr_field(64'(address), OFF_W, IDX_W));
  assign req_tag = TAG_W'(addr_field(64'(address), OFF_W + IDX_W, TAG_W));

  icache_line_array #(
    .SETS   (SETS),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we        (wr_en),
    .wr_index  (lat_idx),
    .wr_tag    (lat_tag),
    .wr_line   (mem_data),
    .clear_all (flush),
    .rd_index  (req_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line)
  );

  // Lookup in IDLE; a same-edge flush forces the lookup to miss.
  assign lookup_hit = (state == IDLE) && cpu_req && rd_valid && (rd_tag == req_tag) && !flush;
  assign miss_start = (state == IDLE) && cpu_req && !lookup_hit;

  // Next-state and registered-output computation.
  always_comb begin
    state_n    = state;
    instr_n    = instr_q;
    hit_n      = 1'b0;
    mem_addr_n = mem_addr_q;
    lat_tag_n  = lat_tag;
    lat_idx_n  = lat_idx;
    lat_off_n  = lat_off;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (lookup_hit) begin
          hit_n   = 1'b1;
          instr_n = rd_line[req_off*INSTR_W +: INSTR_W];
        end else if (miss_start) begin
          lat_tag_n  = req_tag;
          lat_idx_n  = req_idx;
          lat_off_n  = req_off;
          mem_addr_n = ADDR_W'(line_addr(64'(address), OFF_W));
          state_n    = REFILL;
        end
      end
      REFILL: begin
        if (mem_valid) begin
          wr_en   = 1'b1;
          hit_n   = 1'b1;
          // Bypass: return the word from the incoming line, not the array.
          instr_n = mem_data[lat_off*INSTR_W +: INSTR_W];
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      instr_q    <= '0;
      hit_q      <= 1'b0;
      mem_addr_q <= '0;
      lat_tag    <= '0;
      lat_idx    <= '0;
      lat_off    <= '0;
    end else begin
      state      <= state_n;
      instr_q    <= instr_n;
      hit_q      <= hit_n;
      mem_addr_q <= mem_addr_n;
      lat_tag    <= lat_tag_n;
      lat_idx    <= lat_idx_n;
      lat_off    <= lat_off_n;
    end
  end

  assign instruction = instr_q;
  assign hit         = hit_q;
  assign mem_addr    = mem_addr_q;
  // Request and busy follow the state so an async reset drops them at once.
  assign mem_req     = (state == REFILL);
  assign busy        = (state == REFILL);

`ifdef ICACHE_PERF_COUNTERS_EN
  // Saturating hit/miss counters; flush does not clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
